// File: rtl/pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen_multi
// Description : Multi-channel PWM generator. Each channel has synchronised,
//               debounced raise/lower buttons, a saturating duty register and
//               a shadow duty copy that only changes at a period boundary.
//               All channels share one edge- or centre-aligned counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen_multi #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8,
    parameter int PERIOD    = 100,
    parameter int STEP      = 10,
    parameter int DEBOUNCE  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           increase_duty,
    input  logic [CHANNELS-1:0]           decrease_duty,
    input  logic                          center_mode,
    output logic [CHANNELS-1:0]           PWM_OUT,
    output logic [CHANNELS*CNT_WIDTH-1:0] duty_o,
    output logic                          period_end
);

    // Debounce counter only has to reach DEBOUNCE-1 before the flip.
    localparam int                  c_DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] c_DUTY_RST = CNT_WIDTH'(PERIOD / 2);
    localparam logic [CNT_WIDTH-1:0] c_PERIOD_N = CNT_WIDTH'(PERIOD);
    localparam logic [CNT_WIDTH-1:0] c_STEP_N   = CNT_WIDTH'(STEP);
    // One extra bit so duty+STEP cannot wrap before the saturation compare.
    localparam logic [CNT_WIDTH:0]   c_PERIOD_X = (CNT_WIDTH + 1)'(PERIOD);
    localparam logic [CNT_WIDTH:0]   c_STEP_X   = (CNT_WIDTH + 1)'(STEP);

    localparam logic [0:0] c_ST_UP   = 1'b0;
    localparam logic [0:0] c_ST_DOWN = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_mode;
    logic                 w_boundary;

    // Shared counter state register; the mode is only re-sampled at a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_UP;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_boundary) begin
                r_mode <= center_mode;
            end
        end
    end

    // Counter next state: sawtooth in edge mode, triangle in centre mode.
    always_comb begin
        w_boundary  = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_mode) begin
            w_boundary = (r_state == c_ST_DOWN) && (r_cnt == '0);
        end else begin
            w_boundary = (r_cnt == c_CNT_LAST);
        end
        if (w_boundary) begin
            // Every period (and any mode change) restarts from UP with cnt 0.
            w_state_nxt = c_ST_UP;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_UP: begin
                    // Reaching the top here only happens in centre mode.
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_ST_DOWN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_ST_DOWN: begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                default: begin
                    w_state_nxt = c_ST_UP;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign period_end = w_boundary;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [1:0]           w_raw;    // [0] raise, [1] lower
        logic [1:0]           w_press;
        logic [CNT_WIDTH-1:0] r_duty;
        logic [CNT_WIDTH-1:0] r_duty_act;
        logic [CNT_WIDTH-1:0] w_duty_nxt;
        logic [CNT_WIDTH:0]   w_inc_sum;
        logic                 r_pwm;

        assign w_raw = {decrease_duty[k], increase_duty[k]};

        for (genvar j = 0; j < 2; j++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_db;
            logic              r_db_q;
            logic              r_press;
            logic [c_DB_W-1:0] r_db_cnt;

            // Synchronise, debounce, then turn the debounced rising edge into a pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_db     <= 1'b0;
                    r_db_q   <= 1'b0;
                    r_press  <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1 <= w_raw[j];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_db) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_db     <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    r_db_q  <= r_db;
                    r_press <= r_db & ~r_db_q;
                end
            end

            assign w_press[j] = r_press;
        end

        assign w_inc_sum = {1'b0, r_duty} + c_STEP_X;

        // Saturating duty update; coincident raise and lower cancel out.
        always_comb begin
            w_duty_nxt = r_duty;
            if (w_press[0] && !w_press[1]) begin
                w_duty_nxt = (w_inc_sum > c_PERIOD_X) ? c_PERIOD_N : w_inc_sum[CNT_WIDTH-1:0];
            end else if (w_press[1] && !w_press[0]) begin
                // Compare first so the subtraction can never wrap below zero.
                w_duty_nxt = ({1'b0, r_duty} < c_STEP_X) ? '0 : (r_duty - c_STEP_N);
            end
        end

        // Pending duty, boundary-loaded shadow duty and registered compare output.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_duty     <= c_DUTY_RST;
                r_duty_act <= c_DUTY_RST;
                r_pwm      <= 1'b0;
            end else begin
                r_duty <= w_duty_nxt;
                if (w_boundary) begin
                    r_duty_act <= r_duty;
                end
                r_pwm <= (r_cnt < r_duty_act);
            end
        end

        assign PWM_OUT[k]                          = r_pwm;
        assign duty_o[k*CNT_WIDTH +: CNT_WIDTH]    = r_duty;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_gen_multi
// Description : Self-checking bench for pwm_gen_multi. A cycle-level reference
//               model built from period phase arithmetic and button run
//               lengths predicts PWM_OUT, duty_o and period_end every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_gen_multi;

    localparam int CH  = 4;
    localparam int CW  = 4;
    localparam int PER = 10;
    localparam int STP = 1;
    localparam int DB  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     inc;
    logic [CH-1:0]     dec;
    logic              cmode;
    logic [CH-1:0]     pwm;
    logic [CH*CW-1:0]  duty_flat;
    logic              pend;

    always #5 clk = ~clk;

    pwm_gen_multi #(
        .CHANNELS  (CH),
        .CNT_WIDTH (CW),
        .PERIOD    (PER),
        .STEP      (STP),
        .DEBOUNCE  (DB)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .increase_duty (inc),
        .decrease_duty (dec),
        .center_mode   (cmode),
        .PWM_OUT       (pwm),
        .duty_o        (duty_flat),
        .period_end    (pend)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            edge_n;
    int            m_duty [CH];
    int            m_act  [CH];
    bit            m_mode;
    int            m_p;              // position within the current period
    logic [CH-1:0] m_pwm;
    bit            db_st  [2*CH];    // index b<CH raise, b>=CH lower
    bit            run_v  [2*CH];
    int            run_n  [2*CH];
    int            due    [2*CH];    // edge at which the accepted press lands

    function automatic void model_reset();
        edge_n = 0;
        m_mode = 1'b0;
        m_p    = 0;
        m_pwm  = '0;
        for (int k = 0; k < CH; k++) begin
            m_duty[k] = PER / 2;
            m_act[k]  = PER / 2;
        end
        for (int b = 0; b < 2*CH; b++) begin
            db_st[b] = 1'b0;
            run_v[b] = 1'b0;
            run_n[b] = 0;
            due[b]   = -1;
        end
    endfunction

    function automatic int period_len();
        return m_mode ? 2*PER : PER;
    endfunction

    function automatic logic [CH*CW-1:0] exp_duty_flat();
        logic [CH*CW-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) r[k*CW +: CW] = CW'(m_duty[k]);
        return r;
    endfunction

    function automatic void model_edge();
        int len;
        int cnt;
        bit s;
        len = period_len();
        cnt = (m_p < PER) ? m_p : (2*PER - 1 - m_p);
        for (int k = 0; k < CH; k++) m_pwm[k] = (cnt < m_act[k]);
        if (m_p == len - 1) begin
            for (int k = 0; k < CH; k++) m_act[k] = m_duty[k];
            m_mode = cmode;
            m_p    = 0;
        end else begin
            m_p = m_p + 1;
        end
        edge_n = edge_n + 1;
        for (int k = 0; k < CH; k++) begin
            bit up;
            bit dn;
            up = (due[k] == edge_n);
            dn = (due[CH+k] == edge_n);
            if (up && !dn) m_duty[k] = (m_duty[k] + STP > PER) ? PER : m_duty[k] + STP;
            if (dn && !up) m_duty[k] = (m_duty[k] < STP) ? 0 : m_duty[k] - STP;
        end
        // A level is accepted once DB consecutive samples hold it; the step
        // then lands DB+3 edges after the first of those samples.
        for (int b = 0; b < 2*CH; b++) begin
            s = (b < CH) ? inc[b] : dec[b-CH];
            if (s == run_v[b]) run_n[b] = run_n[b] + 1;
            else begin
                run_v[b] = s;
                run_n[b] = 1;
            end
            if (run_n[b] == DB && run_v[b] != db_st[b]) begin
                db_st[b] = run_v[b];
                if (run_v[b]) due[b] = (edge_n - DB + 1) + DB + 3;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs();
        check_val("pwm_out", 64'(pwm), 64'(m_pwm));
        check_val("duty_o", 64'(duty_flat), 64'(exp_duty_flat()));
        check_val("period_end", 64'(pend), 64'(m_p == period_len() - 1));
    endtask

    task automatic check_reset_vals(input string tag);
        logic [CH*CW-1:0] rst_flat;
        for (int k = 0; k < CH; k++) rst_flat[k*CW +: CW] = CW'(PER / 2);
        check_val({tag, "_pwm"}, 64'(pwm), 64'(0));
        check_val({tag, "_duty"}, 64'(duty_flat), 64'(rst_flat));
        check_val({tag, "_pend"}, 64'(pend), 64'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b < CH) inc[b] = v;
        else        dec[b-CH] = v;
    endtask

    task automatic press(input int b, input int hold, input int gap);
        set_btn(b, 1'b1);
        ticks(hold);
        set_btn(b, 1'b0);
        ticks(gap);
    endtask

    task automatic random_phase(input int n);
        int left [2*CH];
        bit lvl  [2*CH];
        for (int b = 0; b < 2*CH; b++) begin
            left[b] = 0;
            lvl[b]  = 1'b0;
            set_btn(b, 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 2*CH; b++) begin
                if (left[b] == 0) begin
                    lvl[b]  = ~lvl[b];
                    left[b] = lvl[b] ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 12));
                    set_btn(b, lvl[b]);
                end
                left[b] = left[b] - 1;
            end
            if ($urandom_range(0, 99) == 0) cmode = ~cmode;
            tick();
        end
        inc = '0;
        dec = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        inc   = '0;
        dec   = '0;
        cmode = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("reset");
        end
        rst_n = 1'b1;

        ticks(30);                                  // defaults: 5 of 10 high
        press(0, 10, 12);                           // held press: one step
        press(0, 3, 12);                            // short glitch: ignored
        repeat (7)  press(1, 6, 6);                 // saturate high
        ticks(25);
        repeat (12) press(CH+1, 6, 6);              // saturate low
        ticks(25);
        inc[2] = 1'b1;                              // simultaneous raise/lower
        dec[2] = 1'b1;
        ticks(6);
        inc[2] = 1'b0;
        dec[2] = 1'b0;
        ticks(8);
        ticks(3);
        press(3, 6, 30);                            // mid-period press
        cmode = 1'b1;                               // centre mode mid-period
        ticks(5);
        repeat (3) press(CH+3, 6, 6);
        ticks(60);
        random_phase(600);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        inc   = '0;
        dec   = '0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        cmode = 1'b0;
        rst_n = 1'b1;
        ticks(30);
        random_phase(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Parametrised multi-channel PWM generator. It succeeds the single-channel `pwm_gen`. Each channel has its own synchronised, debounced increase/decrease duty buttons, a saturating duty register and a glitch-free shadow update at period boundaries. All channels share one period counter. The counter runs either edge-aligned (sawtooth) or centre-aligned (triangle). The block sits between board push-buttons and motor/LED drive pins.

## Interface
- `CHANNELS`, 4, number of independent PWM channels (≥1)
- `CNT_WIDTH`, 8, width of counter and duty registers; requires `PERIOD` ≤ 2^`CNT_WIDTH`−1
- `PERIOD`, 100, counter steps per half/full period; duty range is 0..`PERIOD`
- `STEP`, 10, duty change per accepted button press (1 ≤ `STEP` ≤ `PERIOD`)
- `DEBOUNCE`, 4, cycles an input must be stable before it is accepted (≥1)

Ports:
- `clk` input 1: single clock; all logic on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `increase_duty` input `CHANNELS`: per-channel raise button, asynchronous, active-high
- `decrease_duty` input `CHANNELS`: per-channel lower button, asynchronous, active-high
- `center_mode` input 1: 0 = edge-aligned, 1 = centre-aligned; sampled only at a period boundary
- `PWM_OUT` output `CHANNELS`: registered PWM outputs
- `duty_o` output `CHANNELS*CNT_WIDTH`: pending duty registers, with channel k in bits [k*CNT_WIDTH +: CNT_WIDTH]
- `period_end` output 1: one-cycle pulse on the boundary cycle

## Operation
- **Input conditioning, per button bit:**
  - Input passes a 2-FF synchroniser, then a debouncer.
  - The debouncer flips its state only after the synchronised input has differed from it for `DEBOUNCE` consecutive cycles. Any shorter glitch resets the debounce count.
  - A rising edge of the debounced state produces a one-cycle press pulse.
- **Duty register `duty[k]`:**
  - Reset value is `PERIOD`/2 (integer divide).
  - An inc pulse alone sets duty = min(duty+`STEP`, `PERIOD`).
  - A dec pulse alone sets duty = max(duty−`STEP`, 0). The compare happens before subtracting, so there is no underflow.
  - Inc and dec pulses in the same cycle leave duty unchanged.
  - Arithmetic is done at `CNT_WIDTH`+1 bits to avoid overflow at saturation.
- **Shadow register `duty_act[k]`:** loaded from `duty[k]` on the boundary cycle only. `PWM_OUT` uses only `duty_act`, so a mid-period press never alters the current period.
- **Mode register:** loaded from `center_mode` on the boundary cycle only.
- **Counter states:**
  - UP: cnt 0..`PERIOD`−1.
  - DOWN: cnt `PERIOD`−1..0. Used only in centre mode.
- **Edge mode:**
  - UP wraps from `PERIOD`−1 to 0.
  - The boundary is cnt==`PERIOD`−1.
  - Period is `PERIOD` cycles.
- **Centre mode:**
  - UP at `PERIOD`−1 goes to DOWN with cnt unchanged.
  - DOWN at 0 goes to UP with cnt 0.
  - The boundary is DOWN with cnt==0.
  - Period is 2·`PERIOD` cycles.
- **Mode switch:** takes effect at the boundary. The next cycle starts in UP with cnt 0.
- **Output compare:**
  - PWM_OUT[k] is registered (cnt < duty_act[k]).
  - duty 0 gives constant low.
  - duty `PERIOD` gives constant high, with no glitch across the boundary.
  - High time is duty·1 cycles (edge mode) or duty·2 cycles (centre mode), centred on the triangle valley.

## Timing
- **Reset values:**
  - PWM_OUT = 0.
  - period_end = 0.
  - duty_o = `PERIOD`/2 in every field.
  - cnt = 0, state UP.
  - duty_act = `PERIOD`/2.
  - mode = 0.
  - Synchronisers and debouncers = 0.
- **First period:** after `rst_n` deasserts, cnt=0 is seen at the first rising edge. PWM_OUT follows the compare one cycle later.
- **Button latency:** from the first rising edge that samples a held button high, `duty_o` changes exactly `DEBOUNCE`+3 edges later.
- **Release:** is also debounced. A new press needs release, then re-press, each stable for ≥`DEBOUNCE` cycles.
- **Hold:** holding a button gives exactly one step.
- **Duty to output:** a `duty_o` change reaches PWM_OUT at the first boundary after it. Output registration adds 1 further cycle.
- **period_end:** high during the boundary cycle, coincident with the shadow load.
- **Reset mid-operation:** immediately forces all reset values. Duty presses in progress are lost.

## Test plan
- **Reset defaults:** PERIOD=10, CNT_WIDTH=4, STEP=1, DEBOUNCE=4, edge mode. After reset, duty_o=5 per channel and PWM_OUT is high 5 of every 10 cycles; period_end pulses every 10 cycles.
- **Debounce and latency:** hold increase_duty[0] for 10 cycles → duty_o[0] becomes 6 exactly 7 edges after first sample; one step only. A 3-cycle pulse → no change.
- **Saturation:** 7 presses on ch1 → duty 10 (PWM_OUT[1] constant high). 12 decrease presses → duty 0 (constant low). Simultaneous inc+dec on ch2 → unchanged.
- **Shadow update:** press mid-period → current period keeps the old high time; the next period shows the new duty; other channels are unaffected.
- **Centre mode:** assert center_mode mid-period → switch occurs at the next boundary. Period becomes 20 cycles; duty 3 gives 6 high cycles, centred on the cnt=0 turnaround.
- **Async reset mid-period:** drop rst_n between edges → PWM_OUT=0 and duty_o=5 immediately, without waiting for a clock. Operation restarts cleanly after release.
